data_sram_slave: RTL
====================

Name: data_sram_slave

Overview:
- Responder side of the core's data SRAM interface: en / we[3:0] / addr / wdata in, rdata out with one-cycle latency.
- Contains a word-organised data RAM plus a small MMIO register window: free-running timer, LED output register, switch input.
- Instantiated beside the CPU top in the SoC wrapper. Serves as the simulation memory model and as the FPGA data memory.

Parameters:
- RAM_AW, 14, word-address width of the RAM (2^RAM_AW words; default 64 KiB).
- MMIO_HI, 16'hbfaf, value of addr[31:16] that selects the MMIO window.
- LED_W, 16, width of the LED output register.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- data_sram_en  in  1  access request; sampled at posedge clk.
- data_sram_we  in  4  byte write enables; we[i] writes wdata[8i+7:8i].
- data_sram_addr  in  32  byte address; addr[1:0] ignored.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, valid the cycle after the request.
- switch_i  in  8  board switches, asynchronous; double-flopped internally.
- led_o  out  LED_W  LED register.

Behaviour:
- Reset (async assert, sync release): rdata=0, led_o=0, timer=0, switch synchronisers=0. RAM contents are not reset.
- Decode:
  - mmio_sel = (addr[31:16]==MMIO_HI).
  - Otherwise RAM, indexed by addr[RAM_AW+1:2]. Upper address bits are don't-care, so the RAM aliases.
- Every posedge with en=1:
  - Each byte with we[i]=1 is written to the selected target.
  - rdata <= pre-write content of the selected word (read-first), including when we!=0.
- en=0: no write; rdata holds its previous value.
- we!=0 with en=0 is ignored.
- MMIO map (addr[15:0]):
  - 16'hf000 TIMER: 32-bit, +1 every cycle, wraps 32'hffffffff -> 0. A write in the same cycle wins: next = byte-merge(wdata, current), with no increment that cycle.
  - 16'hf020 LED: RW, low LED_W bits significant; reads zero-extended.
  - 16'hf030 SWITCH: RO; returns {24'b0, switch_sync}. Writes are ignored.
  - Any other offset: reads 0, writes ignored.
- Timer read returns the value before this cycle's increment.
- Back-to-back requests are accepted every cycle. There is no stall and no ready signal.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Reset asserted mid-access aborts it: no partial write is guaranteed; rdata=0.

Optional Feature:
- Macro DSRAM_WRCNT_EN.
- Defined:
  - Adds MMIO offset 16'hf040 WRCNT: 32-bit count of accepted writes (en=1 && we!=0, RAM or MMIO). Wraps at 2^32.
  - A write to WRCNT clears it to 0. The write itself is not counted.
  - Reset value 0.
- Undefined: offset f040 behaves as unmapped (reads 0); no counter flops are present.

Decomposition:
- Package dsram_pkg:
  - MMIO offset constants TIMER_OFF, LED_OFF, SWITCH_OFF, WRCNT_OFF.
  - Byte-merge function (we, old, new).
- Sub-module dsram_mmio_regs: timer, LED, switch synchroniser, optional WRCNT, and registered read mux.
- Top level holds:
  - Decode.
  - RAM array with per-byte write.
  - Final rdata select, using the registered mmio_sel from the request cycle.

Test Plan:
- Reset, then write 0x12345678 to RAM 0x00000010 with we=4'hf; read next cycle -> rdata=0x12345678 one cycle after the read request.
- Write 0xAABBCCDD with we=4'b0101 over 0x12345678 at the same address -> readback 0x12BB56DD.
- Same-cycle write 0xCAFEBABE plus read at 0x20 with old value 0x1 -> rdata=0x00000001; next-cycle read -> 0xCAFEBABE.
- Timer:
  - Write 0xFFFFFFFE to 0xbfaff000.
  - Read on the 2nd cycle after the write -> 0xFFFFFFFF.
  - Read on the next cycle -> 0x00000000 (wrap).
- LED and switch:
  - Write 0x0000A5A5 to 0xbfaff020 -> led_o=16'hA5A5 next cycle.
  - Drive switch_i=8'h3C for 3 cycles, then read 0xbfaff030 -> 0x0000003C.
  - Read unmapped 0xbfaff100 -> 0.
- With DSRAM_WRCNT_EN:
  - 5 writes, one cycle with en=0 and we=4'hf, then read 0xbfaff040 -> 5.
  - Write 0xbfaff040, then read it -> 0.
  - Assert resetn=0 mid-sequence -> rdata=0, led_o=0 immediately.

Source files
------------

// File: rtl/dsram_pkg.sv
// ---------------------------------------------------------------------------
// dsram_pkg
// Shared definitions for the data SRAM responder:
//   - MMIO register offsets inside the 64 KiB window selected by addr[31:16]
//   - read-source tag recorded in the request cycle to steer the rdata mux
//   - byte_merge(): applies per-byte write enables to a 32-bit word
// ---------------------------------------------------------------------------
package dsram_pkg;

  localparam logic [15:0] TIMER_OFF  = 16'hf000;
  localparam logic [15:0] LED_OFF    = 16'hf020;
  localparam logic [15:0] SWITCH_OFF = 16'hf030;
  localparam logic [15:0] WRCNT_OFF  = 16'hf040;

  // SRC_NONE is the reset value so rdata reads as zero until the first
  // request, even though the RAM output register itself is not reset.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

  function automatic logic [31:0] byte_merge(
    input logic [3:0]  we,
    input logic [31:0] old_w,
    input logic [31:0] new_w
  );
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dsram_mmio_regs.sv
// ---------------------------------------------------------------------------
// dsram_mmio_regs
// MMIO register block of the data SRAM responder: free-running timer,
// LED output register, double-flopped switch input, optional write counter
// and the registered (read-first) read mux.
//
// Optional feature: macro DSRAM_WRCNT_EN adds the WRCNT register at offset
// WRCNT_OFF. Without it that offset is unmapped and no counter exists.
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   req          data_sram_en of the current cycle
//   mmio_sel     request targets the MMIO window
//   we           byte write enables
//   off          addr[15:0] of the request
//   wdata        write data
//   switch_i     asynchronous board switches
//   rdata        registered read data (pre-write value of the register)
//   led_o        LED register
// ---------------------------------------------------------------------------
module dsram_mmio_regs
  import dsram_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             mmio_sel,
  input  logic [3:0]       we,
  input  logic [15:0]      off,
  input  logic [31:0]      wdata,
  input  logic [7:0]       switch_i,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led_o
);

  logic             acc;
  logic             reg_wr;
  logic [31:0]      timer_q;
  logic [LED_W-1:0] led_q;
  logic [31:0]      led_merged;
  logic [7:0]       sw_meta_q;
  logic [7:0]       sw_sync_q;
  logic [31:0]      rd_mux;
  logic [31:0]      rdata_q;

  assign acc    = req && mmio_sel;
  assign reg_wr = acc && (we != 4'b0000);

  assign led_merged = byte_merge(we, 32'(led_q), wdata);

  // A write to the timer replaces this cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= 32'd0;
    end else if (reg_wr && off == TIMER_OFF) begin
      timer_q <= byte_merge(we, timer_q, wdata);
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q <= '0;
    end else if (reg_wr && off == LED_OFF) begin
      led_q <= led_merged[LED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta_q <= 8'd0;
      sw_sync_q <= 8'd0;
    end else begin
      sw_meta_q <= switch_i;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef DSRAM_WRCNT_EN
  logic        any_wr;
  logic [31:0] wrcnt_q;

  // Counts every accepted write, RAM or MMIO; writing WRCNT clears it and
  // that clearing write is not itself counted.
  assign any_wr = req && (we != 4'b0000);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrcnt_q <= 32'd0;
    end else if (reg_wr && off == WRCNT_OFF) begin
      wrcnt_q <= 32'd0;
    end else if (any_wr) begin
      wrcnt_q <= wrcnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = 32'd0;
    case (off)
      TIMER_OFF:  rd_mux = timer_q;
      LED_OFF:    rd_mux = 32'(led_q);
      SWITCH_OFF: rd_mux = {24'd0, sw_sync_q};
`ifdef DSRAM_WRCNT_EN
      WRCNT_OFF:  rd_mux = wrcnt_q;
`endif
      default:    rd_mux = 32'd0;
    endcase
  end

  // Read-first: the mux sees register values before this edge's update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
    end else if (acc) begin
      rdata_q <= rd_mux;
    end
  end

  assign rdata = rdata_q;
  assign led_o = led_q;

endmodule

// File: rtl/data_sram_slave.sv
// ---------------------------------------------------------------------------
// data_sram_slave
// Responder for the core's data SRAM port: word-organised RAM plus a small
// MMIO window (timer, LEDs, switches; optional write counter when the macro
// DSRAM_WRCNT_EN is defined).
//
// Handshake: there is no ready. Every cycle with data_sram_en=1 is an
// accepted request; bytes with we[i]=1 are written at that edge and
// data_sram_rdata shows the pre-write word from the following cycle on,
// holding until the next request. we is ignored while en=0.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   data_sram_en      request
//   data_sram_we      byte write enables
//   data_sram_addr    byte address (addr[1:0] ignored)
//   data_sram_wdata   write data
//   data_sram_rdata   read data, one cycle after the request
//   switch_i          asynchronous board switches
//   led_o             LED register
// ---------------------------------------------------------------------------
module data_sram_slave
  import dsram_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] MMIO_HI = 16'hbfaf,
  parameter int          LED_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [7:0]       switch_i,
  output logic [LED_W-1:0] led_o
);

  logic              mmio_sel;
  logic              ram_req;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_q;
  logic [31:0]       mmio_rdata;
  rd_src_e           src_q;
  logic              unused_addr_lo;

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  // Upper address bits outside the MMIO window are don't-care: RAM aliases.
  assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);
  assign ram_req  = data_sram_en && !mmio_sel;
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];

  assign unused_addr_lo = ^data_sram_addr[1:0];

  // RAM contents and output register are not reset; src_q masks ram_q
  // until a real access has loaded it.
  always_ff @(posedge clk) begin
    if (ram_req) begin
      ram_q <= mem[ram_idx];
      if (data_sram_we != 4'b0000) begin
        mem[ram_idx] <= byte_merge(data_sram_we, mem[ram_idx], data_sram_wdata);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q <= SRC_NONE;
    end else if (data_sram_en) begin
      src_q <= mmio_sel ? SRC_MMIO : SRC_RAM;
    end
  end

  dsram_mmio_regs #(
    .LED_W (LED_W)
  ) u_mmio (
    .clk      (clk),
    .resetn   (resetn),
    .req      (data_sram_en),
    .mmio_sel (mmio_sel),
    .we       (data_sram_we),
    .off      (data_sram_addr[15:0]),
    .wdata    (data_sram_wdata),
    .switch_i (switch_i),
    .rdata    (mmio_rdata),
    .led_o    (led_o)
  );

  always_comb begin
    data_sram_rdata = 32'd0;
    case (src_q)
      SRC_RAM:  data_sram_rdata = ram_q;
      SRC_MMIO: data_sram_rdata = mmio_rdata;
      default:  data_sram_rdata = 32'd0;
    endcase
  end

endmodule
